fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the IF/ID buffer (`if_id_reg`). Generates the 9-bit PC, issues in-order requests to instruction memory, and queues returned instructions in a 2-entry buffer. It presents `{Curr_Pc, Curr_Instr}` to decode with a valid/ready handshake. Branch redirects from EX flush queued and in-flight fetches.

## Interface
- `PC_W`, 9, PC/instruction-memory byte-address width; must equal `if_id_reg.Curr_Pc` width
- `DEPTH`, 2, fetch-queue entries (power of two, ≥2)
- `clk`  in  1  clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request, one-cycle pulse per fetch
- `imem_addr`  out  PC_W  byte address of the request; valid while `imem_req`=1
- `imem_rvalid`  in  1  response valid; in order, ≥1 cycle after its request
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`
- `redirect`  in  1  taken branch/jump from EX
- `redirect_pc`  in  PC_W  target address, valid with `redirect`
- `id_ready`  in  1  decode accepts the head entry (deasserted by hazard stall)
- `if_id_valid`  out  1  `if_id_o` holds a valid entry
- `if_id_o`  out  `Pipe_Buf_Reg_PKG::if_id_reg`  head entry `{Curr_Pc, Curr_Instr}`

## Operation
- State: `pc` (next fetch address), `outstanding` (one request in flight), `discard` (drop the next response), queue of DEPTH `{pc, instr}` entries plus `count`.
- At most one request is outstanding.
- Issue condition: `outstanding`=0, or `imem_rvalid`=1 this cycle; and queue occupancy after this cycle's push/pop is < DEPTH; and `redirect`=0.
- On issue: `imem_req`=1, `imem_addr`=`pc`; `pc` ← `pc`+4 modulo 2^PC_W. For example, 508 → 0; no overflow flag.
- Response handling: `imem_rvalid` with `outstanding`=1 and `discard`=0 pushes `{addr of that request, imem_rdata}`. With `discard`=1, the response is dropped and `discard` is cleared. With `outstanding`=0, the response is ignored.
- Pop: `if_id_valid`=1 and `id_ready`=1 removes the head.
- Push and pop may occur in the same cycle; `count` is then unchanged.
- Redirect has priority over push, pop and issue:
  - queue cleared, `count` ← 0
  - `pc` ← `redirect_pc`
  - `discard` ← 1 if a request is still outstanding after this cycle, otherwise 0
  - no request issued that cycle
- Back-to-back redirects: the last one wins.
- Low `id_ready` holds the head entry stable indefinitely.
- Fetch stops only when the queue is full.
- Reset (any time, including mid-request): `pc`=0, `outstanding`=0, `discard`=0, `count`=0, `imem_req`=0, `if_id_valid`=0, `if_id_o`=0. A response arriving after reset is ignored.

## Timing
- `imem_req` is combinational from registered state plus `imem_rvalid`, `redirect` and `id_ready`. `if_id_o`/`if_id_valid` are driven from queue registers only, with no input-to-output combinational path.
- First request: first rising edge after `reset` deasserts, `imem_addr`=0.
- Latency: request at cycle t, `imem_rvalid` at t+L, entry visible on `if_id_o` at t+L+1.
- Throughput:
  - L=1 with `id_ready`=1: one instruction per cycle sustained.
  - L=k: one per k cycles.
- Redirect at cycle t: a request to `redirect_pc` is issued at t+1 if nothing is outstanding. Otherwise it is issued in the cycle the stale response returns. `if_id_valid`=0 from t+1 until the first new entry.

## Structure
- `Pipe_Buf_Reg_PKG` gains `localparam PC_W = 9` and `typedef struct packed { logic [8:0] pc; logic [31:0] instr; } fetch_entry`.
- `if_id_o` uses the existing `if_id_reg`.
- Sub-module `fetch_queue`: DEPTH-entry circular FIFO with read/write pointers, count, simultaneous push/pop and synchronous clear. `fetch_unit` holds the PC, the outstanding/discard flags and the issue logic.

## Test plan
- Reset release, L=1, `id_ready`=1 → requests to 0, 4, 8, … on consecutive cycles. `if_id_o` shows `{0, word0}` two cycles after the first request, then one entry per cycle.
- `id_ready`=0 for 10 cycles, L=1 → exactly 2 entries queued, `imem_req` low once full, head stable. On release, entries drain in order and fetch resumes at PC 8.
- L=3 with `redirect` to 0x40 while a request to 0x10 is in flight → the 0x10 response is dropped. Next request 0x40 is issued in the cycle that response returns, and the first valid entry is `{0x40, …}`.
- `redirect_pc`=508 → fetches 508, 0, 4 (wrap). `Curr_Pc` values are 508, 0, 4.
- Redirect in the same cycle as push and pop → queue empty next cycle, no entry lost from the new path.
- `reset` asserted mid-request, late `imem_rvalid` after release → ignored. All outputs 0, first request to 0.

Source files
------------

// File: rtl/pipe_buf_reg_pkg.sv
// rtl/pipe_buf_reg_pkg.sv - pipeline buffer register types shared by the fetch stage and IF/ID
// Contents:
//   PC_W        instruction-memory byte-address width
//   if_id_reg   IF/ID buffer payload {Curr_Pc, Curr_Instr}
//   fetch_entry one fetch-queue slot {pc, instr}
package Pipe_Buf_Reg_PKG;

   localparam int PC_W = 9;

   typedef struct packed {
      logic [8:0]  Curr_Pc;
      logic [31:0] Curr_Instr;
   } if_id_reg;

   typedef struct packed {
      logic [8:0]  pc;
      logic [31:0] instr;
   } fetch_entry;

   function automatic if_id_reg entry_to_if_id(fetch_entry e);
      if_id_reg r;
      r.Curr_Pc    = e.pc;
      r.Curr_Instr = e.instr;
      return r;
   endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// rtl/fetch_unit_queue.sv - circular FIFO holding fetched {pc, instr} entries
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   clear           synchronous flush, dominates push/pop
//   push, push_data write one entry at the tail
//   pop             remove the head (ignored when empty)
//   head            head entry, zero when empty (registers only)
//   empty, count    occupancy
module fetch_queue
   import Pipe_Buf_Reg_PKG::*;
#(
   parameter int  DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  fetch_entry       push_data,
   input  logic             pop,
   output fetch_entry       head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   fetch_entry       mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full queue can still accept a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   // Storage needs no reset: head is masked to zero while the queue is empty.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, in-order imem requests, 2-entry queue to IF/ID
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   imem_req, imem_addr        one-cycle fetch request and its byte address
//   imem_rvalid, imem_rdata    in-order instruction response
//   redirect, redirect_pc      taken branch/jump from EX, flushes queued and in-flight fetches
//   id_ready                   decode accepts the head entry
//   if_id_valid, if_id_o       head entry {Curr_Pc, Curr_Instr} toward decode
module fetch_unit
   import Pipe_Buf_Reg_PKG::*;
#(
   parameter int PC_W  = 9,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            if_id_valid,
   output if_id_reg        if_id_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PC_W-1:0]  pc;
   logic [PC_W-1:0]  pc_nxt;
   logic [PC_W-1:0]  req_addr;
   logic [PC_W-1:0]  req_addr_nxt;
   logic             outstanding;
   logic             outstanding_nxt;
   logic             discard;
   logic             discard_nxt;

   logic             resp;
   logic             push;
   logic             pop;
   logic             issue;
   logic [CNT_W:0]   occ_next;
   logic [CNT_W-1:0] q_count;
   logic             q_empty;
   fetch_entry       q_head;
   fetch_entry       push_entry;

   // A response only belongs to us while a request is in flight.
   assign resp = imem_rvalid & outstanding;
   assign push = resp & ~discard & ~redirect;
   assign pop  = if_id_valid & id_ready & ~redirect;

   assign occ_next = {1'b0, q_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);

   // Reset gates the request so nothing leaves the stage while held in reset.
   assign issue = reset & ~redirect & (~outstanding | imem_rvalid)
                & (occ_next < (CNT_W+1)'(DEPTH));

   assign imem_req  = issue;
   assign imem_addr = pc;

   assign push_entry.pc    = req_addr;
   assign push_entry.instr = imem_rdata;

   always_comb begin
      pc_nxt          = pc;
      req_addr_nxt    = req_addr;
      outstanding_nxt = outstanding;
      discard_nxt     = discard;

      if (issue) begin
         outstanding_nxt = 1'b1;
         req_addr_nxt    = pc;
         pc_nxt          = pc + PC_W'(4);
      end else if (resp) begin
         outstanding_nxt = 1'b0;
      end

      if (resp && discard) discard_nxt = 1'b0;

      // A redirect never issues, so outstanding_nxt here says whether a stale
      // response is still on its way and must be swallowed.
      if (redirect) begin
         pc_nxt      = redirect_pc;
         discard_nxt = outstanding_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= '0;
         req_addr    <= '0;
         outstanding <= 1'b0;
         discard     <= 1'b0;
      end else begin
         pc          <= pc_nxt;
         req_addr    <= req_addr_nxt;
         outstanding <= outstanding_nxt;
         discard     <= discard_nxt;
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .reset     (reset),
      .clear     (redirect),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (q_head),
      .empty     (q_empty),
      .count     (q_count)
   );

   assign if_id_valid = ~q_empty;
   assign if_id_o     = entry_to_if_id(q_head);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a fixed-latency imem model
module tb_fetch_unit;
   import Pipe_Buf_Reg_PKG::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [8:0]  imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [8:0]  redirect_pc = '0;
   logic        id_ready = 1'b0;
   logic        if_id_valid;
   if_id_reg    if_id_o;

   always #5 clk = ~clk;

   fetch_unit #(.PC_W(9), .DEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_ready    (id_ready),
      .if_id_valid (if_id_valid),
      .if_id_o     (if_id_o)
   );

   int vectors = 0;
   int miscompares = 0;
   int lat = 1;
   int n_req = 0;
   logic [8:0] exp_addr_q[$];
   if_id_reg   exp_ent_q[$];

   function automatic logic [31:0] word_at(logic [8:0] a);
      return {16'hC0DE, 7'h00, a};
   endfunction

   function automatic if_id_reg mk(logic [8:0] a);
      if_id_reg r;
      r.Curr_Pc    = a;
      r.Curr_Instr = word_at(a);
      return r;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Instruction memory: answers each request exactly lat cycles later.
   logic       pend = 1'b0;
   logic [8:0] pend_addr = '0;
   int         pend_age = 0;
   initial begin
      forever begin
         @(posedge clk); #1;
         imem_rvalid = 1'b0;
         if (pend) begin
            pend_age++;
            if (pend_age == lat) begin
               imem_rvalid = 1'b1;
               imem_rdata  = word_at(pend_addr);
               pend        = 1'b0;
            end
         end
         @(negedge clk);
         if (imem_req) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_age  = 0;
         end
      end
   end

   // Monitor: compares every request address and every accepted entry.
   initial begin
      logic [8:0] a;
      if_id_reg   e;
      forever begin
         @(negedge clk);
         if (imem_req) begin
            n_req++;
            if (exp_addr_q.size() > 0) begin
               a = exp_addr_q.pop_front();
               check("req_addr", imem_addr, a);
            end
         end
         if (reset && if_id_valid && id_ready && !redirect && exp_ent_q.size() > 0) begin
            e = exp_ent_q.pop_front();
            check("if_id_o", if_id_o, e);
         end
      end
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic flush();
      exp_addr_q.delete();
      exp_ent_q.delete();
   endtask

   task automatic exp_path(logic [8:0] start, int n_addr, int n_ent);
      for (int i = 0; i < n_addr; i++) exp_addr_q.push_back(start + 9'(4 * i));
      for (int i = 0; i < n_ent; i++)  exp_ent_q.push_back(mk(start + 9'(4 * i)));
   endtask

   // Holds reset long enough for any pending response to expire, checks the
   // reset outputs, then releases at the start of cycle c0.
   task automatic start(int l, logic rdy);
      reset    = 1'b0;
      redirect = 1'b0;
      id_ready = rdy;
      lat      = l;
      step(4);
      @(negedge clk);
      check("rst_req", imem_req, 0);
      check("rst_valid", if_id_valid, 0);
      check("rst_if_id_o", if_id_o, 0);
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
      int n0;

      // Streaming at L=1: one request and one entry per cycle.
      flush();
      exp_path(9'd0, 11, 11);
      start(1, 1'b1);
      @(negedge clk);
      check("s1_first_req", imem_req, 1);
      step(1); @(negedge clk);
      check("s1_c1_valid", if_id_valid, 0);
      step(1); @(negedge clk);
      check("s1_c2_head", {if_id_valid, if_id_o}, {1'b1, mk(9'd0)});
      step(1);
      n0 = n_req;
      step(8);
      check("s1_throughput", n_req - n0, 8);
      step(3);
      check("s1_drained", exp_ent_q.size(), 0);

      // Stall: two entries fill the queue, fetch stops, head holds.
      flush();
      exp_path(9'd0, 5, 4);
      start(1, 1'b0);
      n0 = n_req;
      step(2);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("s2_hold_head", {if_id_valid, if_id_o}, {1'b1, mk(9'd0)});
         check("s2_full_no_req", imem_req, 0);
         step(1);
      end
      check("s2_req_count", n_req - n0, 2);
      id_ready = 1'b1;
      step(6);
      check("s2_drained", exp_ent_q.size(), 0);
      check("s2_addr_done", exp_addr_q.size(), 0);

      // L=3, redirect to 0x40 while the 0x10 fetch is in flight.
      flush();
      exp_path(9'd0, 5, 3);
      start(3, 1'b1);
      step(13);
      redirect = 1'b1; redirect_pc = 9'h040;
      flush();
      exp_path(9'h040, 2, 2);
      step(1);
      redirect = 1'b0;
      @(negedge clk);
      check("s3_c14_req", imem_req, 0);
      check("s3_c14_valid", if_id_valid, 0);
      step(1); @(negedge clk);
      check("s3_c15_req", {imem_req, imem_addr}, {1'b1, 9'h040});
      step(2); @(negedge clk);
      check("s3_c17_valid", if_id_valid, 0);
      step(1); @(negedge clk);
      check("s3_c18_valid", if_id_valid, 0);
      step(1); @(negedge clk);
      check("s3_c19_head", {if_id_valid, if_id_o}, {1'b1, mk(9'h040)});
      step(5);
      check("s3_drained", exp_ent_q.size(), 0);

      // Redirect to 508 in a cycle with push and pop; then PC wraps to 0.
      flush();
      exp_path(9'd0, 4, 2);
      start(1, 1'b1);
      step(4);
      redirect = 1'b1; redirect_pc = 9'd508;
      flush();
      exp_addr_q.push_back(9'd508); exp_addr_q.push_back(9'd0); exp_addr_q.push_back(9'd4);
      exp_ent_q.push_back(mk(9'd508)); exp_ent_q.push_back(mk(9'd0)); exp_ent_q.push_back(mk(9'd4));
      step(1);
      redirect = 1'b0;
      @(negedge clk);
      check("s4_flush_empty", if_id_valid, 0);
      check("s4_req_508", {imem_req, imem_addr}, {1'b1, 9'd508});
      step(1); @(negedge clk);
      check("s4_c6_valid", if_id_valid, 0);
      step(1); @(negedge clk);
      check("s4_c7_pc", if_id_o.Curr_Pc, 9'd508);
      step(4);
      check("s4_drained", exp_ent_q.size(), 0);

      // Back-to-back redirects: the second target wins.
      redirect = 1'b1; redirect_pc = 9'h020;
      flush();
      step(1);
      redirect_pc = 9'h060;
      flush();
      exp_path(9'h060, 2, 2);
      step(1);
      redirect = 1'b0;
      @(negedge clk);
      check("s5_last_wins", {imem_req, imem_addr}, {1'b1, 9'h060});
      step(4);
      check("s5_drained", exp_ent_q.size(), 0);

      // Reset mid-request; the stale response lands right after release.
      flush();
      exp_addr_q.push_back(9'd0);
      start(3, 1'b1);
      step(1);
      reset = 1'b0;
      flush();
      exp_path(9'd0, 2, 2);
      @(negedge clk);
      check("s6_rst_req", imem_req, 0);
      check("s6_rst_valid", if_id_valid, 0);
      check("s6_rst_if_id_o", if_id_o, 0);
      step(2);
      reset = 1'b1;
      @(negedge clk);
      check("s6_first_req", {imem_req, imem_addr}, {1'b1, 9'd0});
      step(1); @(negedge clk);
      check("s6_stale_ignored", if_id_valid, 0);
      step(7);
      check("s6_drained", exp_ent_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
